mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//  Memory-side responder for the control unit's memory handshake. Drives MAR/MBR/rnw
//  and waits on WMFC; this block captures the request, performs the read or write on an
//  internal RAM after programmable wait states, then pulses mfc (memory function complete).
//  Sits between the CU/datapath (MAR, MBR) and storage; mbr_load tells the datapath to latch rdata.
// PARAMETERS
//  AW        8   address width (MAR width); RAM depth = 2**AW words
//  DW        8   data word width (matches 8-bit instruction/data bus)
//  WAIT_CYC  2   wait states inserted before access; 0 allowed (WAIT state skipped)
// PORTS
//  CLK       in   1    system clock, all logic on rising edge
//  RST_N     in   1    synchronous active-low reset
//  req       in   1    memory request (CU asserts with MAR_in/WMFC), level-sampled in IDLE
//  rnw       in   1    1 = read, 0 = write; sampled with req
//  addr      in   AW   address from MAR; sampled with req
//  wdata     in   DW   write data from MBR; sampled with req
//  rdata     out  DW   registered read data; valid while mfc=1 on reads, held afterwards
//  mfc       out  1    one-cycle completion pulse
//  mbr_load  out  1    = mfc & captured rnw; datapath latches rdata into MBR
//  busy      out  1    1 in any state other than IDLE
//  par_err   out  1    parity error flag (MEM_PARITY_EN only; else tied 0)
// BEHAVIOUR
//  - Reset (RST_N=0 at edge): state=IDLE, mfc=0, mbr_load=0, busy=0, rdata=0, par_err=0,
//    wait counter=0. RAM contents not cleared; unwritten locations undefined.
//  - Reset mid-transaction aborts it: a write not yet in ACCESS is not performed; no mfc issued.
//  - FSM: IDLE -> (req=1) WAIT if WAIT_CYC>0 else ACCESS; capture addr/rnw/wdata on that edge.
//    WAIT: counter loads WAIT_CYC-1 on entry, decrements; at 0 -> ACCESS.
//    ACCESS (1 cycle): write RAM[addr]<=wdata, or rdata<=RAM[addr]; -> DONE.
//    DONE (1 cycle): mfc=1, mbr_load=rnw; -> IDLE unconditionally.
//  - Latency: capture at edge E0; mfc high for exactly one cycle after edge E0+WAIT_CYC+1.
//  - Inputs are ignored while busy=1; changes to addr/wdata/rnw mid-transaction have no effect.
//  - req still high in IDLE after DONE starts a new transaction (back-to-back, one IDLE cycle
//    between consecutive mfc pulses, minimum). CU drops req on mfc to avoid a repeat.
//  - Write data visible to a read issued on any later transaction (no bypass needed: serialised).
//  - Address wraps naturally within AW bits; no out-of-range condition exists.
//  - rdata is updated only by reads; writes leave rdata unchanged.
// CONFIGURATION
//  MEM_PARITY_EN defined: RAM stores DW+1 bits (even parity over data, computed at write).
//    On read ACCESS, parity recomputed; par_err<=1 in DONE with mfc if mismatch, cleared at next
//    capture. Read data still returned. Unwritten locations may flag par_err.
//  MEM_PARITY_EN undefined: RAM is DW bits, par_err tied 0, no parity logic synthesised.
// TESTING
//  1) Reset: RST_N=0 two cycles with req=1 -> mfc=0, busy=0, rdata=0, state IDLE after release.
//  2) WAIT_CYC=2: write 0xA5 to 0x10 captured at E0 -> mfc=1 only after E3, mbr_load=0;
//     then read 0x10 -> rdata=0xA5, mfc=mbr_load=1 for one cycle.
//  3) WAIT_CYC=0: read/write latency -> mfc one cycle after E1; verify WAIT never entered.
//  4) Hold req=1 continuously, rnw=1, addr changing each cycle -> each mfc returns data of
//    the address sampled at its capture edge; one IDLE cycle between mfc pulses.
//  5) Assert RST_N=0 during WAIT of write 0x3C->0x20 -> no mfc; later read 0x20 returns prior value.
//  6) MEM_PARITY_EN: write 0x0F, force-flip stored bit via hierarchical ref, read -> par_err=1
//    with mfc; next clean read -> par_err=0. Without macro par_err stays 0 throughout.

Source files
------------

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - memory-side responder for the CU MAR/MBR/WMFC handshake
//
// Captures a request (addr/rnw/wdata) while idle. It inserts WAIT_CYC wait states and then
// performs one access on an internal RAM. After that it pulses mfc for one cycle.
// mbr_load is the datapath's cue to latch rdata into MBR.
//
// Optional feature macro: MEM_PARITY_EN (stores an even-parity bit per word and flags
// par_err on a read whose recomputed parity disagrees; without it par_err is tied 0).
//
// Ports:
//   CLK       in   1   system clock, rising edge
//   RST_N     in   1   synchronous active-low reset
//   req       in   1   memory request, level-sampled in IDLE
//   rnw       in   1   1 = read, 0 = write, sampled with req
//   addr      in   AW  word address (MAR), sampled with req
//   wdata     in   DW  write data (MBR), sampled with req
//   rdata     out  DW  registered read data, held until the next read
//   mfc       out  1   one-cycle memory-function-complete pulse
//   mbr_load  out  1   mfc qualified by a read
//   busy      out  1   high whenever a transaction is in flight
//   par_err   out  1   parity mismatch on the completing read
module mem_responder #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int WAIT_CYC = 2
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          req,
  input  logic          rnw,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          mfc,
  output logic          mbr_load,
  output logic          busy,
  output logic          par_err
);

  localparam int CW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
  localparam logic [CW-1:0] WAIT_LOAD = CW'((WAIT_CYC > 0) ? WAIT_CYC - 1 : 0);

`ifdef MEM_PARITY_EN
  localparam int MW = DW + 1;
`else
  localparam int MW = DW;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic [AW-1:0] addr_q;
  logic          rnw_q;
  logic [DW-1:0] wdata_q;

  logic [MW-1:0] mem [2**AW];
  logic [MW-1:0] wr_word;
  logic [MW-1:0] rd_word;

`ifdef MEM_PARITY_EN
  // Parity bit sits above the data so the stored word has even parity overall.
  assign wr_word = {^wdata_q, wdata_q};
`else
  assign wr_word = wdata_q;
`endif
  assign rd_word = mem[addr_q];

  // RAM is never cleared. Gating the write with RST_N means a reset always wins, so an
  // aborted transaction cannot leave a partial write behind.
  always_ff @(posedge CLK) begin
    if (RST_N && state == S_ACCESS && !rnw_q) begin
      mem[addr_q] <= wr_word;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      addr_q   <= '0;
      rnw_q    <= 1'b0;
      wdata_q  <= '0;
      rdata    <= '0;
      mfc      <= 1'b0;
      mbr_load <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            addr_q  <= addr;
            rnw_q   <= rnw;
            wdata_q <= wdata;
            busy    <= 1'b1;
            if (WAIT_CYC > 0) begin
              state    <= S_WAIT;
              wait_cnt <= WAIT_LOAD;
            end else begin
              state <= S_ACCESS;
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt == '0) begin
            state <= S_ACCESS;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        S_ACCESS: begin
          if (rnw_q) begin
            rdata <= rd_word[DW-1:0];
          end
          mfc      <= 1'b1;
          mbr_load <= rnw_q;
          state    <= S_DONE;
        end
        S_DONE: begin
          mfc      <= 1'b0;
          mbr_load <= 1'b0;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MEM_PARITY_EN
  // The flag rises together with mfc and stays up until the next request is captured.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      par_err <= 1'b0;
    end else if (state == S_IDLE && req) begin
      par_err <= 1'b0;
    end else if (state == S_ACCESS && rnw_q) begin
      par_err <= ^rd_word;
    end
  end
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder (WAIT_CYC=2 and WAIT_CYC=0)
module tb_mem_responder;

  localparam int W = 2;
  localparam int P = W + 3;  // cycles per transaction when req is held high

  logic       CLK;
  logic       RST_N;
  logic       req, rnw;
  logic [7:0] addr, wdata;
  logic [7:0] rdata;
  logic       mfc, mbr_load, busy, par_err;

  logic       req0, rnw0;
  logic [7:0] addr0, wdata0;
  logic [7:0] rdata0;
  logic       mfc0, mbr_load0, busy0, par_err0;

  mem_responder #(.AW(8), .DW(8), .WAIT_CYC(W)) dut (
    .CLK(CLK), .RST_N(RST_N), .req(req), .rnw(rnw), .addr(addr), .wdata(wdata),
    .rdata(rdata), .mfc(mfc), .mbr_load(mbr_load), .busy(busy), .par_err(par_err)
  );

  mem_responder #(.AW(8), .DW(8), .WAIT_CYC(0)) dut0 (
    .CLK(CLK), .RST_N(RST_N), .req(req0), .rnw(rnw0), .addr(addr0), .wdata(wdata0),
    .rdata(rdata0), .mfc(mfc0), .mbr_load(mbr_load0), .busy(busy0), .par_err(par_err0)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: word array plus "known" flags, and the last value returned by a read.
  logic [7:0] mm [256];
  bit         mk [256];
  logic [7:0] last_rd;
  bit         last_known;

  typedef struct {
    bit         r;
    logic [7:0] d;
    bit         known;
    bit         perr;
    int         cap;
  } exp_t;
  exp_t sb[$];

  // Called on the negedge just before the capture edge.
  task automatic push(input bit r, input logic [7:0] a, input logic [7:0] d, input bit perr);
    exp_t e;
    if (r) begin
      last_rd    = mm[a];
      last_known = mk[a];
    end else begin
      mm[a] = d;
      mk[a] = 1'b1;
    end
    e.r = r; e.d = last_rd; e.known = last_known; e.perr = perr; e.cap = cyc + 1;
    sb.push_back(e);
  endtask

  bit mfc_prev = 1'b0;
  always @(negedge CLK) begin
    if (RST_N && mfc) begin
      if (sb.size() == 0) begin
        chk("spurious_mfc", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("mfc_latency", 32'(cyc - e.cap), 32'(W + 1));
        chk("mbr_load", {31'd0, mbr_load}, {31'd0, e.r});
        chk("busy_at_mfc", {31'd0, busy}, 32'd1);
        chk("par_err", {31'd0, par_err}, {31'd0, e.perr});
        if (e.known) chk(e.r ? "rdata_read" : "rdata_held", {24'd0, rdata}, {24'd0, e.d});
      end
    end
    if (mfc && mfc_prev) chk("mfc_one_cycle", 32'd1, 32'd0);
    mfc_prev = mfc;
  end

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 50) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic txn(input bit r, input logic [7:0] a, input logic [7:0] d);
    wait_idle();
    req = 1'b1; rnw = r; addr = a; wdata = d;
    push(r, a, d, 1'b0);
    @(negedge CLK);
    // Garbage on the inputs while busy must be ignored.
    req = 1'b0; rnw = 1'($urandom); addr = 8'($urandom); wdata = 8'($urandom);
  endtask

  // WAIT_CYC=0 instance: capture, ACCESS for one cycle, mfc on the next.
  task automatic txn0(input bit r, input logic [7:0] a, input logic [7:0] d,
                      input logic [7:0] exp);
    req0 = 1'b1; rnw0 = r; addr0 = a; wdata0 = d;
    @(negedge CLK);
    req0 = 1'b0; addr0 = 8'($urandom); wdata0 = 8'($urandom);
    chk("w0_no_mfc_yet", {31'd0, mfc0}, 32'd0);
    chk("w0_busy", {31'd0, busy0}, 32'd1);
    @(negedge CLK);
    chk("w0_mfc", {31'd0, mfc0}, 32'd1);
    chk("w0_mbr_load", {31'd0, mbr_load0}, {31'd0, r});
    chk("w0_rdata", {24'd0, rdata0}, {24'd0, exp});
    @(negedge CLK);
    chk("w0_mfc_drop", {31'd0, mfc0}, 32'd0);
    chk("w0_idle", {31'd0, busy0}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mm[i] = 8'h00;
      mk[i] = 1'b0;
    end
    last_rd = 8'h00; last_known = 1'b1;

    // Reset held two edges with req high.
    RST_N = 1'b0; req = 1'b1; rnw = 1'b1; addr = 8'h00; wdata = 8'h00;
    req0 = 1'b1; rnw0 = 1'b1; addr0 = 8'h00; wdata0 = 8'h00;
    repeat (2) @(negedge CLK);
    chk("rst_mfc", {31'd0, mfc}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rdata", {24'd0, rdata}, 32'd0);
    chk("rst_mbr_load", {31'd0, mbr_load}, 32'd0);
    chk("rst_par_err", {31'd0, par_err}, 32'd0);
    chk("rst0_busy", {31'd0, busy0}, 32'd0);
    req = 1'b0; req0 = 1'b0;
    RST_N = 1'b1;
    @(negedge CLK);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    // Directed write/read of 0xA5 at 0x10.
    txn(1'b0, 8'h10, 8'hA5);
    txn(1'b1, 8'h10, 8'h00);

    // WAIT_CYC=0 latency and data.
    txn0(1'b0, 8'h33, 8'h5A, 8'h00);
    txn0(1'b1, 8'h33, 8'h00, 8'h5A);
    txn0(1'b0, 8'h34, 8'hC3, 8'h5A);
    txn0(1'b1, 8'h34, 8'h00, 8'hC3);
    txn0(1'b1, 8'h33, 8'h00, 8'h5A);

    // Seed low addresses, then random mixed traffic.
    for (int i = 0; i < 16; i++) txn(1'b0, 8'(i), 8'($urandom));
    for (int i = 0; i < 40; i++) txn(1'($urandom), 8'($urandom_range(0, 31)), 8'($urandom));

    // req held high, address changing every cycle: captures every P edges.
    wait_idle();
    for (int i = 0; i < 6 * P; i++) begin
      req = 1'b1; rnw = 1'b1; addr = 8'($urandom_range(0, 15));
      if (i % P == 0) push(1'b1, addr, 8'h00, 1'b0);
      @(negedge CLK);
    end
    req = 1'b0;

    // Reset during WAIT of write 0x3C -> 0x20 aborts it.
    txn(1'b0, 8'h20, 8'h77);
    wait_idle();
    req = 1'b1; rnw = 1'b0; addr = 8'h20; wdata = 8'h3C;
    @(negedge CLK);
    req = 1'b0;
    chk("abort_in_wait", {31'd0, busy}, 32'd1);
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_rdata", {24'd0, rdata}, 32'd0);
    RST_N = 1'b1;
    last_rd = 8'h00; last_known = 1'b1;
    repeat (6) @(negedge CLK);
    txn(1'b1, 8'h20, 8'h00);

`ifdef MEM_PARITY_EN
    txn(1'b0, 8'h40, 8'h0F);
    wait_idle();
    dut.mem[8'h40] = dut.mem[8'h40] ^ 9'h001;
    mm[8'h40] = 8'h0E;
    req = 1'b1; rnw = 1'b1; addr = 8'h40;
    push(1'b1, 8'h40, 8'h00, 1'b1);
    @(negedge CLK);
    req = 1'b0;
    txn(1'b1, 8'h10, 8'h00);
`endif

    // Drain.
    begin
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
        @(negedge CLK);
        n++;
      end
    end
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    chk("final_par_err", {31'd0, par_err}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
